// File: rtl/voice_mixer.sv
// Time-multiplexed voice mixer: snapshots all voices on SampleTick, then accumulates voice*level one voice per clock.
// Latency: Valid pulses NUM_VOICES+1 clocks after the sampling tick edge; Waveform/Clip are held until the next Valid.
// Backpressure: none; a tick seen while Busy is dropped and flagged by a one-cycle Overrun pulse.
module voice_mixer #(
  parameter int WAVE_DEPTH  = 8,
  parameter int NUM_VOICES  = 4,
  parameter int LEVEL_DEPTH = 4,
  parameter int OUT_SHIFT   = 2
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic                              SampleTick,
  input  logic [NUM_VOICES*WAVE_DEPTH-1:0]  Voices,
  input  logic [NUM_VOICES*LEVEL_DEPTH-1:0] Levels,
  input  logic [NUM_VOICES-1:0]             VoiceEnable,
  output logic [WAVE_DEPTH-1:0]             Waveform,
  output logic                              Valid,
  output logic                              Clip,
  output logic                              Busy,
  output logic                              Overrun
);

  // Accumulator is sized so a full-scale sum of all voices can never wrap.
  localparam int ACC_W  = WAVE_DEPTH + LEVEL_DEPTH + $clog2(NUM_VOICES) + 1;
  localparam int PROD_W = WAVE_DEPTH + LEVEL_DEPTH;
  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int SHIFT  = LEVEL_DEPTH + OUT_SHIFT;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [ACC_W-1:0] SAT_MAX  = {{(ACC_W-WAVE_DEPTH){1'b0}}, {WAVE_DEPTH{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Control decodes from the FSM
  logic start_mix;
  logic acc_en;
  logic emit;
  logic tick_drop;

  // Snapshot of the inputs taken at the start of a mix
  logic [WAVE_DEPTH-1:0]  snap_voice [NUM_VOICES];
  logic [LEVEL_DEPTH-1:0] snap_level [NUM_VOICES];
  logic [NUM_VOICES-1:0]  snap_en;

  logic [IDX_W-1:0]  idx;
  logic [ACC_W-1:0]  acc;
  logic [PROD_W-1:0] cur_prod;
  logic [ACC_W-1:0]  scaled;

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> ACCUM -> OUTPUT -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (SampleTick) state_nxt = S_ACCUM;
      S_ACCUM:  if (idx == LAST_IDX) state_nxt = S_OUTPUT;
      S_OUTPUT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output/control decode; a tick anywhere outside IDLE (including OUTPUT) is an overrun
  always_comb begin
    start_mix = 1'b0;
    acc_en    = 1'b0;
    emit      = 1'b0;
    Busy      = 1'b0;
    tick_drop = 1'b0;
    case (state)
      S_IDLE: begin
        start_mix = SampleTick;
      end
      S_ACCUM: begin
        acc_en    = 1'b1;
        Busy      = 1'b1;
        tick_drop = SampleTick;
      end
      S_OUTPUT: begin
        emit      = 1'b1;
        Busy      = 1'b1;
        tick_drop = SampleTick;
      end
      default: begin
        Busy      = 1'b1;
      end
    endcase
  end

  // Capture voices, levels and enables at mix start so later input changes are ignored
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        snap_voice[i] <= '0;
        snap_level[i] <= '0;
      end
      snap_en <= '0;
    end else if (start_mix) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        snap_voice[i] <= Voices[i*WAVE_DEPTH +: WAVE_DEPTH];
        snap_level[i] <= Levels[i*LEVEL_DEPTH +: LEVEL_DEPTH];
      end
      snap_en <= VoiceEnable;
    end
  end

  // Weighted contribution of the voice currently selected by idx
  always_comb begin
    cur_prod = '0;
    if (snap_en[idx]) begin
      cur_prod = PROD_W'(snap_voice[idx]) * PROD_W'(snap_level[idx]);
    end
  end

  // Voice index and running sum; both cleared when a new mix starts
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      idx <= '0;
      acc <= '0;
    end else if (start_mix) begin
      idx <= '0;
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc + ACC_W'(cur_prod);
      if (idx != LAST_IDX) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Drop the level fraction bits plus the headroom shift before saturating
  always_comb begin
    scaled = acc >> SHIFT;
  end

  // Output sample, clip flag and strobes; Waveform/Clip only move on the OUTPUT edge
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Waveform <= '0;
      Clip     <= 1'b0;
      Valid    <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      Valid   <= emit;
      Overrun <= tick_drop;
      if (emit) begin
        if (scaled > SAT_MAX) begin
          Waveform <= '1;
          Clip     <= 1'b1;
        end else begin
          Waveform <= scaled[WAVE_DEPTH-1:0];
          Clip     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: directed mixes with hand-computed results checked by a queue-based scoreboard.
// A second instance with zero headroom shift exercises saturation.
module tb_voice_mixer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        tick_a;
  logic        tick_b;
  logic [31:0] Voices;
  logic [15:0] Levels;
  logic [3:0]  VoiceEnable;

  logic [7:0]  wave_a, wave_b;
  logic        valid_a, valid_b;
  logic        clip_a, clip_b;
  logic        busy_a, busy_b;
  logic        ovr_a, ovr_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int ovr_cyc = -1;
  int ovr_b_cnt = 0;
  int busy_cnt = 0;
  int busy_b_cnt = 0;
  int c0;

  typedef struct {
    logic [7:0] wave;
    logic       clip;
    int         cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  voice_mixer #(.WAVE_DEPTH(8), .NUM_VOICES(4), .LEVEL_DEPTH(4), .OUT_SHIFT(2)) u_dut_a (
    .Clock(Clock), .Reset(Reset), .SampleTick(tick_a), .Voices(Voices), .Levels(Levels),
    .VoiceEnable(VoiceEnable), .Waveform(wave_a), .Valid(valid_a), .Clip(clip_a),
    .Busy(busy_a), .Overrun(ovr_a)
  );

  voice_mixer #(.WAVE_DEPTH(8), .NUM_VOICES(4), .LEVEL_DEPTH(4), .OUT_SHIFT(0)) u_dut_b (
    .Clock(Clock), .Reset(Reset), .SampleTick(tick_b), .Voices(Voices), .Levels(Levels),
    .VoiceEnable(VoiceEnable), .Waveform(wave_b), .Valid(valid_b), .Clip(clip_b),
    .Busy(busy_b), .Overrun(ovr_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wave_a"}, 32'(wave_a), 0);
    chk({tag, "_valid_a"}, 32'(valid_a), 0);
    chk({tag, "_clip_a"}, 32'(clip_a), 0);
    chk({tag, "_busy_a"}, 32'(busy_a), 0);
    chk({tag, "_ovr_a"}, 32'(ovr_a), 0);
    chk({tag, "_wave_b"}, 32'(wave_b), 0);
    chk({tag, "_clip_b"}, 32'(clip_b), 0);
  endtask

  // Raise tick_a so the next edge is E0; returns at #1 after E0 with c0 = cycle of E0.
  task automatic fire_a(output int e0);
    tick_a = 1'b1;
    @(posedge Clock); #1;
    tick_a = 1'b0;
    e0 = cyc;
  endtask

  task automatic fire_b(output int e0);
    tick_b = 1'b1;
    @(posedge Clock); #1;
    tick_b = 1'b0;
    e0 = cyc;
  endtask

  task automatic push_a(input logic [7:0] w, input logic c, input int e0);
    exp_t e;
    e.wave = w; e.clip = c; e.cyc = e0 + 5;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] w, input logic c, input int e0);
    exp_t e;
    e.wave = w; e.clip = c; e.cyc = e0 + 5;
    qb.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  initial begin
    exp_t ea, eb;
    Reset       = 1'b0;
    tick_a      = 1'($urandom);
    tick_b      = 1'($urandom);
    Voices      = $urandom;
    Levels      = 16'($urandom);
    VoiceEnable = 4'($urandom);

    // Monitor: compare every Valid against the scoreboard, track Overrun and Busy
    fork
      forever begin
        @(negedge Clock);
        if (valid_a) begin
          if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected_valid actual=1 expected=0 cyc=%0d wave=%0h", cyc, wave_a);
          end else begin
            ea = qa.pop_front();
            chk("a_wave", 32'(wave_a), 32'(ea.wave));
            chk("a_clip", 32'(clip_a), 32'(ea.clip));
            chk("a_latency", 32'(cyc), 32'(ea.cyc));
          end
        end
        if (valid_b) begin
          if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_valid actual=1 expected=0 cyc=%0d wave=%0h", cyc, wave_b);
          end else begin
            eb = qb.pop_front();
            chk("b_wave", 32'(wave_b), 32'(eb.wave));
            chk("b_clip", 32'(clip_b), 32'(eb.clip));
            chk("b_latency", 32'(cyc), 32'(eb.cyc));
          end
        end
        if (ovr_a) begin ovr_cnt++; ovr_cyc = cyc; end
        if (ovr_b) ovr_b_cnt++;
        if (busy_a) busy_cnt++;
        if (busy_b) busy_b_cnt++;
      end
    join_none

    // 1: reset held with random inputs, then released with no tick
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk_idle_outputs("rst");
    #1;
    tick_a = 1'b0; tick_b = 1'b0;
    Reset = 1'b1;
    idle_cycles(5);
    @(negedge Clock);
    chk_idle_outputs("post_rst");
    idle_cycles(1);

    // 2: all voices 0x80, levels 0xF -> 7680>>6 = 0x78; Busy exactly 5 cycles
    Voices = {4{8'h80}}; Levels = {4{4'hF}}; VoiceEnable = 4'hF;
    busy_cnt = 0;
    fire_a(c0);
    push_a(8'h78, 1'b0, c0);
    idle_cycles(8);
    chk("busy_cycles", 32'(busy_cnt), 5);

    // 3: only voice0 enabled: 255*15 = 3825>>6 = 0x3B
    Voices = {8'hAA, 8'hAA, 8'hAA, 8'hFF}; Levels = {4{4'hF}}; VoiceEnable = 4'b0001;
    fire_a(c0);
    push_a(8'h3B, 1'b0, c0);
    idle_cycles(8);

    // Held output across idle time
    chk("hold_wave", 32'(wave_a), 32'h3B);

    // 4: zero-shift instance saturates, then all levels 0 gives 0 and clears Clip
    Voices = {4{8'hFF}}; Levels = {4{4'hF}}; VoiceEnable = 4'hF;
    fire_b(c0);
    push_b(8'hFF, 1'b1, c0);
    idle_cycles(8);
    Levels = 16'h0000;
    fire_b(c0);
    push_b(8'h00, 1'b0, c0);
    idle_cycles(8);

    // 5: tick at E2 with changed voices is dropped; single Valid with the snapshot value
    Voices = {4{8'h80}}; Levels = {4{4'hF}}; VoiceEnable = 4'hF;
    ovr_cnt = 0;
    fire_a(c0);
    push_a(8'h78, 1'b0, c0);
    @(posedge Clock); #1;
    Voices = 32'h0; tick_a = 1'b1;
    @(posedge Clock); #1;
    tick_a = 1'b0;
    idle_cycles(8);
    chk("ovr_count", 32'(ovr_cnt), 1);
    chk("ovr_cycle", 32'(ovr_cyc), 32'(c0 + 2));

    // 6: reset during ACCUM aborts the mix, then three ticks spaced 6 cycles apart
    Voices = {4{8'hFF}}; Levels = {4{4'hF}}; VoiceEnable = 4'hF;
    fire_a(c0);
    @(posedge Clock);
    @(posedge Clock); #1;
    Reset = 1'b0;
    #1;
    chk_idle_outputs("mid_rst");
    idle_cycles(3);
    Reset = 1'b1;
    idle_cycles(2);
    ovr_cnt = 0;
    Voices = {4{8'h40}}; Levels = {4{4'h8}}; VoiceEnable = 4'hF;
    fire_a(c0);
    push_a(8'h20, 1'b0, c0);
    idle_cycles(5);
    VoiceEnable = 4'b0011;
    fire_a(c0);
    push_a(8'h10, 1'b0, c0);
    idle_cycles(5);
    Voices = {4{8'hFF}}; Levels = {4{4'hF}}; VoiceEnable = 4'hF;
    fire_a(c0);
    push_a(8'hEF, 1'b0, c0);
    idle_cycles(10);
    chk("spaced_ovr", 32'(ovr_cnt), 0);
    chk("b_never_ovr", 32'(ovr_b_cnt), 0);

    // Drain: every expected Valid must have appeared within the budget
    for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) begin
      @(posedge Clock);
    end
    #1;
    chk("drain_a", 32'(qa.size()), 0);
    chk("drain_b", 32'(qb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
